// File: rtl/sound_scheduler.sv
// Shared speaker sequencer: latches jump/point/death requests, arbitrates by fixed
// priority with preemption, and plays the winner's note table as a registered square wave.
module sound_scheduler #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_jump,
    input  logic       req_point,
    input  logic       req_death,
    input  logic       mute,
    output logic       wave_out,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);
    // state    | meaning
    // S_IDLE   | silent, waiting for a pending request
    // S_LOAD   | output low, note 0 of active_id about to start
    // S_PLAY   | sequencing notes of active_id
    // S_FINISH | one-cycle done pulse, back to idle
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    function automatic logic [15:0] note_half(input logic [1:0] id, input logic [1:0] idx);
        logic [15:0] h;
        case ({id, idx})
            4'b01_00: h = 16'd47801;
            4'b01_01: h = 16'd35816;
            4'b10_00: h = 16'd37922;
            4'b10_01: h = 16'd31888;
            4'b10_10: h = 16'd23900;
            4'b11_00: h = 16'd63776;
            4'b11_10: h = 16'd63776;
            4'b11_11: h = 16'd56818;
            default:  h = 16'd0;
        endcase
        return h;
    endfunction

    function automatic logic [7:0] note_dur(input logic [1:0] id, input logic [1:0] idx);
        logic [7:0] d;
        case ({id, idx})
            4'b01_00: d = 8'd40;
            4'b01_01: d = 8'd60;
            4'b10_00: d = 8'd50;
            4'b10_01: d = 8'd50;
            4'b10_10: d = 8'd100;
            4'b11_00: d = 8'd100;
            4'b11_01: d = 8'd50;
            4'b11_10: d = 8'd100;
            4'b11_11: d = 8'd200;
            default:  d = 8'd1;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] id);
        return (id == 2'd3) ? 2'd3 : (id == 2'd2) ? 2'd2 : (id == 2'd1) ? 2'd1 : 2'd0;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:1]  pend_q, pend_d;
    logic [1:0]  active_id_q, active_id_d;
    logic [1:0]  note_idx_q, note_idx_d;
    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  tick_q, tick_d;
    logic        tone_q, tone_d;
    logic        wave_q, wave_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  pick_id;
    logic [3:1]  clr_vec;
    logic        take_pick;
    logic [15:0] cur_half;
    logic [7:0]  cur_dur;
    logic        note_end;

    always_comb begin
        if (pend_q[3])      pick_id = 2'd3;
        else if (pend_q[2]) pick_id = 2'd2;
        else if (pend_q[1]) pick_id = 2'd1;
        else                pick_id = 2'd0;
    end

    assign cur_half = note_half(active_id_q, note_idx_q);
    assign cur_dur  = note_dur(active_id_q, note_idx_q);
    assign note_end = (presc_q == TICK_LAST) && (tick_q == cur_dur - 8'd1);

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        note_idx_d  = note_idx_q;
        tone_cnt_d  = tone_cnt_q;
        presc_d     = presc_q;
        tick_d      = tick_q;
        tone_d      = tone_q;
        done_d      = 1'b0;
        take_pick   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_id != 2'd0) take_pick = 1'b1;
            end
            S_LOAD: begin
                state_d    = S_PLAY;
                note_idx_d = 2'd0;
                tone_cnt_d = 16'd0;
                presc_d    = 16'd0;
                tick_d     = 8'd0;
                tone_d     = (note_half(active_id_q, 2'd0) != 16'd0);
            end
            S_PLAY: begin
                // An equal id counts as a preemption so a repeated request restarts the sound.
                if (pick_id != 2'd0 && pick_id >= active_id_q) begin
                    take_pick = 1'b1;
                end else if (note_end) begin
                    if (note_idx_q == last_idx(active_id_q)) begin
                        state_d     = S_FINISH;
                        active_id_d = 2'd0;
                        tone_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        note_idx_d = note_idx_q + 2'd1;
                        tone_cnt_d = 16'd0;
                        presc_d    = 16'd0;
                        tick_d     = 8'd0;
                        tone_d     = (note_half(active_id_q, note_idx_q + 2'd1) != 16'd0);
                    end
                end else begin
                    if (presc_q == TICK_LAST) begin
                        presc_d = 16'd0;
                        tick_d  = tick_q + 8'd1;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                    if (cur_half != 16'd0) begin
                        if (tone_cnt_q == cur_half - 16'd1) begin
                            tone_cnt_d = 16'd0;
                            tone_d     = ~tone_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_pick) begin
            state_d     = S_LOAD;
            active_id_d = pick_id;
            note_idx_d  = 2'd0;
            tone_d      = 1'b0;
        end
        clr_vec = take_pick ? {pick_id == 2'd3, pick_id == 2'd2, pick_id == 2'd1} : 3'b000;
        // Set is applied after clear so a request landing on the clearing edge survives.
        pend_d  = (pend_q & ~clr_vec) | {req_death, req_point, req_jump};
        busy_d  = (state_d == S_LOAD) || (state_d == S_PLAY);
        wave_d  = tone_d & ~mute;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_q      <= 3'b000;
            active_id_q <= 2'd0;
            note_idx_q  <= 2'd0;
            tone_cnt_q  <= 16'd0;
            presc_q     <= 16'd0;
            tick_q      <= 8'd0;
            tone_q      <= 1'b0;
            wave_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            active_id_q <= active_id_d;
            note_idx_q  <= note_idx_d;
            tone_cnt_q  <= tone_cnt_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            tone_q      <= tone_d;
            wave_q      <= wave_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign wave_out  = wave_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign done      = done_q;
endmodule
